// File: rtl/palette_fade_ctrl.sv
// Brightness fader between the background palette lookup and the VGA colour outputs.
// Brightness moves one step per FRAMES_PER_STEP frame_start pulses, so frames never tear.
module palette_fade_ctrl #(
  parameter int unsigned FRAMES_PER_STEP = 4,
  parameter bit          START_VISIBLE   = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_start,
  input  logic       fade_in_req,
  input  logic       fade_out_req,
  input  logic [3:0] red_in,
  input  logic [3:0] green_in,
  input  logic [3:0] blue_in,
  output logic [3:0] red_out,
  output logic [3:0] green_out,
  output logic [3:0] blue_out,
  output logic [4:0] level,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_BLACK    = 2'd0,
    ST_FADE_IN  = 2'd1,
    ST_VISIBLE  = 2'd2,
    ST_FADE_OUT = 2'd3
  } state_e;

  localparam state_e     RST_STATE = START_VISIBLE ? ST_VISIBLE : ST_BLACK;
  localparam logic [4:0] RST_LEVEL = START_VISIBLE ? 5'd16 : 5'd0;
  localparam logic [7:0] DIV_LAST  = 8'(FRAMES_PER_STEP - 1);

  // Level 16 is unity gain: (c*16)>>4 == c.
  function automatic logic [3:0] scale(input logic [3:0] c, input logic [4:0] lvl);
    return 4'(({5'd0, c} * {4'd0, lvl}) >> 4);
  endfunction

  state_e     state_q, state_d;
  logic [4:0] level_q, level_d;
  logic [7:0] div_q, div_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] red_q, green_q, blue_q;
  logic       accept_in_s, accept_out_s, fading_s;

  // Next-state logic: request acceptance takes priority over stepping.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    div_d        = div_q;
    done_d       = 1'b0;
    fading_s     = (state_q == ST_FADE_IN) || (state_q == ST_FADE_OUT);
    accept_out_s = fade_out_req && ((state_q == ST_VISIBLE) || (state_q == ST_FADE_IN));
    accept_in_s  = fade_in_req && !fade_out_req &&
                   ((state_q == ST_BLACK) || (state_q == ST_FADE_OUT));
    if (accept_out_s) begin
      state_d = ST_FADE_OUT;
      div_d   = 8'd0;
    end else if (accept_in_s) begin
      state_d = ST_FADE_IN;
      div_d   = 8'd0;
    end else if (frame_start && fading_s) begin
      if (div_q == DIV_LAST) begin
        div_d = 8'd0;
        case (state_q)
          ST_FADE_IN: begin
            // A reversal right at full level still finishes on the next step.
            if (level_q >= 5'd15) begin
              level_d = 5'd16;
              state_d = ST_VISIBLE;
              done_d  = 1'b1;
            end else begin
              level_d = level_q + 5'd1;
            end
          end
          ST_FADE_OUT: begin
            if (level_q <= 5'd1) begin
              level_d = 5'd0;
              state_d = ST_BLACK;
              done_d  = 1'b1;
            end else begin
              level_d = level_q - 5'd1;
            end
          end
          default: begin
            level_d = level_q;
          end
        endcase
      end else begin
        div_d = div_q + 8'd1;
      end
    end else begin
      div_d = div_q;
    end
    busy_d = (state_d == ST_FADE_IN) || (state_d == ST_FADE_OUT);
  end

  // Control state, level and status registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= RST_STATE;
      level_q <= RST_LEVEL;
      div_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      div_q   <= div_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Colour pipeline: scaled by the level held in the input cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      red_q   <= 4'd0;
      green_q <= 4'd0;
      blue_q  <= 4'd0;
    end else begin
      red_q   <= scale(red_in, level_q);
      green_q <= scale(green_in, level_q);
      blue_q  <= scale(blue_in, level_q);
    end
  end

  assign red_out   = red_q;
  assign green_out = green_q;
  assign blue_out  = blue_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: doc/palette_fade_ctrl.md
Name: palette_fade_ctrl

Overview:
- Sits between the background palette lookup (3-bit index -> 12-bit RGB) and the VGA colour outputs.
- Sequences screen fades (fade-in/fade-out across game-state changes) by scaling every palette colour by a brightness level.
- The level steps only at frame boundaries, so no frame ever tears.
- Provides busy/done status so the game-state FSM can wait for a fade to finish before swapping backgrounds.

Parameters:
FRAMES_PER_STEP, 4, number of frame_start pulses between brightness steps (legal range 1..255).
START_VISIBLE, 0, reset level: 0 = black (level 0), 1 = full brightness (level 16).

Ports:
Clk  input  1  pixel/system clock
Reset_n  input  1  asynchronous active-low reset
frame_start  input  1  single-cycle pulse at the start of vertical blank
fade_in_req  input  1  single-cycle request to fade towards full brightness
fade_out_req  input  1  single-cycle request to fade towards black
red_in  input  4  palette red for the current pixel
green_in  input  4  palette green
blue_in  input  4  palette blue
red_out  output  4  scaled red, registered
green_out  output  4  scaled green, registered
blue_out  output  4  scaled blue, registered
level  output  5  current brightness, 0..16
busy  output  1  high while in FADE_IN or FADE_OUT
done  output  1  one-cycle pulse when a fade reaches its end level

Behaviour:
- Clock and reset:
  - One clock, Clk. Reset_n is asynchronous, active-low.
  - Reset values: level = 0 (16 if START_VISIBLE), state = BLACK (VISIBLE if START_VISIBLE), frame divider = 0, RGB outputs = 0, busy = 0, done = 0.
- Colour datapath:
  - Each channel out = (in * level) >> 4; 4x5-bit product, 9-bit intermediate, keep bits [7:4].
  - Level 16 passes input unchanged; level 0 gives 0.
  - Registered with 1-cycle latency: inputs at cycle N appear at N+1 using the level held at N.
- States: BLACK (level 0), FADE_IN, VISIBLE (level 16), FADE_OUT.
- Request acceptance:
  - fade_in_req in BLACK or FADE_OUT -> FADE_IN.
  - fade_out_req in VISIBLE or FADE_IN -> FADE_OUT.
  - Any other request is ignored: fade_in in VISIBLE/FADE_IN, fade_out in BLACK/FADE_OUT.
  - fade_in_req and fade_out_req in the same cycle: fade_out wins.
  - Reversal mid-fade starts from the current level; level does not jump.
  - Accepting a request clears the frame divider to 0.
  - busy rises on the cycle after the request.
- Stepping:
  - In FADE_IN/FADE_OUT, every frame_start increments the divider.
  - When the divider reaches FRAMES_PER_STEP-1 on a frame_start: it wraps to 0 and level moves by ±1.
  - level only ever changes on a frame_start cycle.
  - FADE_IN reaching 16 -> VISIBLE, same cycle done=1 for one cycle. FADE_OUT reaching 0 -> BLACK, same cycle done=1.
  - A full fade takes 16*FRAMES_PER_STEP frame_starts.
- Request and frame_start in the same cycle: the request is processed (state change, divider clear); no step occurs that cycle.
- frame_start outside a fade: ignored, divider held at 0.
- Reset mid-fade: immediate return to reset values; no done pulse.

Test Plan:
1. Reset with START_VISIBLE=0, red_in/green_in/blue_in = F/8/3 -> outputs 0/0/0, level=0, busy=0; release reset, pulse fade_in_req -> busy=1 on the next cycle, level still 0.
2. FRAMES_PER_STEP=4, fade_in_req then 64 frame_start pulses -> level increments after every 4th pulse; reaches 16 on pulse 64 with one done pulse; outputs F/8/3 one cycle after input.
3. At level 8, input F/8/3 -> outputs 7/4/1 (15*8>>4 = 7, 8*8>>4 = 4, 3*8>>4 = 1), with exactly 1-cycle latency.
4. Mid fade-in at level 5, pulse fade_out_req -> state FADE_OUT, divider cleared; after 4 more frame_starts level=4; after 20 total level=0, done pulses, busy=0.
5. In VISIBLE, assert fade_in_req and fade_out_req in the same cycle as a frame_start -> FADE_OUT entered, level stays 16 that cycle, first step occurs 4 frame_starts later.
6. Assert Reset_n low mid-fade at level 9 -> asynchronous clear: level 0, outputs 0, busy 0, no done pulse; fade_in_req while in VISIBLE -> ignored, busy stays 0.
